// File: rtl/display_pkg.sv
// display_pkg: constants shared by the display shift-out slice.
//  - SEG_0..SEG_9, SEG_BLANK: 7-segment glyphs, bit order {g,f,e,d,c,b,a}, active high.
//  - state_t: frame sequencer states IDLE / SHIFT / LATCH.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/display_shift_out_if.sv
// display_shift_out_if: bundle between the refresh source / pins and display_shift_out.
//  master: drives ref_pulse, digits_bcd, dp_mask; observes the serial pins, busy, dbg_state.
//  slave : the shift-out block.
//
// Request protocol: ref_pulse is a single-cycle request. When busy is low it starts a frame
// immediately and the data is captured on that edge. When busy is high the request is
// remembered (any number of them collapse into one) and served right after the current
// frame's latch pulse, with the data captured at that moment.
interface display_shift_out_if #(
   parameter int DIGITS = 6
);
   logic                      ref_pulse;
   logic [4*DIGITS-1:0]       digits_bcd;
   logic [DIGITS-1:0]         dp_mask;
   logic                      ser_data;
   logic                      ser_clk;
   logic                      ser_latch;
   logic                      busy;
   display_pkg::state_t       dbg_state;

   modport master (
      output ref_pulse, digits_bcd, dp_mask,
      input  ser_data, ser_clk, ser_latch, busy, dbg_state
   );

   modport slave (
      input  ref_pulse, digits_bcd, dp_mask,
      output ser_data, ser_clk, ser_latch, busy, dbg_state
   );
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to 7-segment glyph.
//  bcd_i : 4-bit digit value
//  seg_o : {g,f,e,d,c,b,a}, active high; codes 10-15 give a blank glyph
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_shift_out.sv
// display_shift_out: serialises a DIGITS-wide BCD count plus decimal points into a
// 74HC595-style chain (data / shift clock / storage latch).
//  clk, reset     : system clock, asynchronous active-high reset
//  bus (slave)    : ref_pulse, digits_bcd, dp_mask in; ser_data, ser_clk, ser_latch,
//                   busy, dbg_state out
// Frame: DIGITS bytes {dp,g,f,e,d,c,b,a}, highest digit first, bit 7 first. Each bit is
// CLK_DIV clocks with ser_clk low followed by CLK_DIV clocks high; then ser_latch is
// high for CLK_DIV clocks. All outputs come straight from flops.
module display_shift_out #(
   parameter int DIGITS       = 6,
   parameter int CLK_DIV      = 4,
   parameter int COMMON_ANODE = 0
) (
   input  logic               clk,
   input  logic               reset,
   display_shift_out_if.slave bus
);
   import display_pkg::*;

   localparam int NBITS = 8 * DIGITS;
   localparam int DW    = $clog2(CLK_DIV) + 1;
   localparam int BW    = $clog2(NBITS);

   localparam logic [DW-1:0] DIV_ONE    = DW'(1);
   localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] LATCH_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_ONE    = BW'(1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
   localparam logic [7:0]    INV_MASK   = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;

   state_t           state_q;
   logic [NBITS-1:0] frame_q;
   logic [DW-1:0]    div_q;
   logic [BW-1:0]    bit_q;
   logic             pending_q;
   logic             ser_data_q;
   logic             ser_clk_q;
   logic             ser_latch_q;
   logic             busy_q;

   logic [NBITS-1:0] frame_w;
   logic [DW-1:0]    div_inc;
   logic [BW-1:0]    bit_inc;

   // Encoded frame, digit i occupies byte i, so the top byte (highest digit) leaves first.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [6:0] seg;
      bcd_to_7seg u_enc (
         .bcd_i (bus.digits_bcd[4*i +: 4]),
         .seg_o (seg)
      );
      assign frame_w[8*i +: 8] = {bus.dp_mask[i], seg} ^ INV_MASK;
   end

   assign div_inc = div_q + DIV_ONE;
   assign bit_inc = bit_q + BIT_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         div_q       <= '0;
         bit_q       <= '0;
         pending_q   <= 1'b0;
         ser_data_q  <= 1'b0;
         ser_clk_q   <= 1'b0;
         ser_latch_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ref_pulse) begin
                  // First bit goes out directly from the encoder so it is valid next cycle.
                  frame_q    <= frame_w;
                  ser_data_q <= frame_w[NBITS-1];
                  ser_clk_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  div_q      <= '0;
                  bit_q      <= '0;
                  state_q    <= SHIFT;
               end
            end

            SHIFT: begin
               if (bus.ref_pulse) begin
                  pending_q <= 1'b1;
               end
               if (div_q == DIV_LAST) begin
                  div_q     <= '0;
                  ser_clk_q <= 1'b0;
                  if (bit_q == BIT_LAST) begin
                     ser_data_q  <= 1'b0;
                     ser_latch_q <= 1'b1;
                     state_q     <= LATCH;
                  end else begin
                     bit_q      <= bit_inc;
                     frame_q    <= {frame_q[NBITS-2:0], 1'b0};
                     ser_data_q <= frame_q[NBITS-2];
                  end
               end else begin
                  div_q     <= div_inc;
                  ser_clk_q <= (div_inc >= DIV_HALF);
               end
            end

            LATCH: begin
               if (div_q == LATCH_LAST) begin
                  div_q       <= '0;
                  bit_q       <= '0;
                  ser_latch_q <= 1'b0;
                  // A request arriving in this very cycle is served as well.
                  if (pending_q || bus.ref_pulse) begin
                     pending_q  <= 1'b0;
                     frame_q    <= frame_w;
                     ser_data_q <= frame_w[NBITS-1];
                     state_q    <= SHIFT;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  div_q <= div_inc;
                  if (bus.ref_pulse) begin
                     pending_q <= 1'b1;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ser_data  = ser_data_q;
   assign bus.ser_clk   = ser_clk_q;
   assign bus.ser_latch = ser_latch_q;
   assign bus.busy      = busy_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_display_shift_out.sv
// tb_display_shift_out: bench for display_shift_out.
//  dut_a: DIGITS=6, CLK_DIV=4, common cathode; frames checked byte-wise by a negedge monitor.
//  dut_b: DIGITS=6, CLK_DIV=1, common anode; frames checked cycle by cycle.
module tb_display_shift_out;
   import display_pkg::*;

   localparam int DIGITS  = 6;
   localparam int NBITS   = 8 * DIGITS;
   localparam int CDIV_A  = 4;
   localparam int FRAME_A = (2 * NBITS + 1) * CDIV_A;
   localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   display_shift_out_if #(.DIGITS(DIGITS)) a_if ();
   display_shift_out_if #(.DIGITS(DIGITS)) b_if ();

   display_shift_out #(.DIGITS(DIGITS), .CLK_DIV(CDIV_A), .COMMON_ANODE(0)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   display_shift_out #(.DIGITS(DIGITS), .CLK_DIV(1), .COMMON_ANODE(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];
   int byte_cnt  = 0;
   int latch_cnt = 0;
   int last_busy = 0;
   int busy_run  = 0;
   int latch_run = 0;
   int clk_run   = 0;
   int nbits     = 0;
   int frame_bits = 0;
   logic prev_clk  = 1'b0;
   logic hi_bit    = 1'b0;
   logic low_clean = 1'b0;
   logic [7:0] sh  = 8'h00;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_byte(input logic [3:0] d, input logic dp, input bit ca);
      logic [7:0] b;
      int idx;
      idx = int'(d);
      b = {dp, 7'h00};
      if (idx <= 9) b[6:0] = GLYPH[idx];
      if (ca) b = ~b;
      return b;
   endfunction

   task automatic push_frame(input logic [4*DIGITS-1:0] bcd, input logic [DIGITS-1:0] dp);
      for (int i = DIGITS - 1; i >= 0; i--) begin
         exp_q.push_back(model_byte(bcd[4*i +: 4], dp[i], 1'b0));
      end
   endtask

   // ---------------- monitor for dut_a ----------------
   always @(negedge clk) begin
      if (reset) begin
         nbits = 0; frame_bits = 0; busy_run = 0; latch_run = 0; clk_run = 0;
         prev_clk = 1'b0; low_clean = 1'b0; sh = 8'h00;
      end else begin
         if (a_if.ser_clk != prev_clk) begin
            if (prev_clk) chk("a_clk_high_len", 64'(clk_run), 64'(CDIV_A));
            else if (low_clean) chk("a_clk_low_len", 64'(clk_run), 64'(CDIV_A));
            clk_run = 1;
            if (!a_if.ser_clk) low_clean = !a_if.ser_latch;
         end else begin
            clk_run++;
         end
         if (a_if.ser_latch) low_clean = 1'b0;

         if (a_if.ser_clk && !prev_clk) begin
            hi_bit = a_if.ser_data;
            sh = {sh[6:0], a_if.ser_data};
            nbits++;
            frame_bits++;
            if (nbits == 8) begin
               nbits = 0;
               byte_cnt++;
               chk("a_exp_avail", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) chk("a_byte", 64'(sh), 64'(exp_q.pop_front()));
            end
         end else if (a_if.ser_clk && prev_clk) begin
            chk("a_data_stable", 64'(a_if.ser_data), 64'(hi_bit));
         end

         if (a_if.ser_latch) begin
            if (latch_run == 0) begin
               chk("a_frame_bits", 64'(frame_bits), 64'(NBITS));
               frame_bits = 0;
            end
            latch_run++;
            chk("a_latch_pins", 64'({a_if.ser_clk, a_if.ser_data}), 64'(0));
         end else if (latch_run != 0) begin
            chk("a_latch_len", 64'(latch_run), 64'(CDIV_A));
            latch_cnt++;
            latch_run = 0;
         end

         if (a_if.busy) busy_run++;
         else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run = 0;
         end
         prev_clk = a_if.ser_clk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [4*DIGITS-1:0] bcd, input logic [DIGITS-1:0] dp);
      a_if.digits_bcd = bcd;
      a_if.dp_mask    = dp;
   endtask

   task automatic pulse_a();
      a_if.ref_pulse = 1'b1;
      tick();
      a_if.ref_pulse = 1'b0;
   endtask

   task automatic start_checks(input string tag, input logic first_bit);
      chk({tag, "_start_pins"},
          64'({a_if.busy, a_if.ser_latch, a_if.ser_clk, a_if.ser_data}),
          64'({1'b1, 1'b0, 1'b0, first_bit}));
      chk({tag, "_start_state"}, 64'(a_if.dbg_state), 64'(SHIFT));
   endtask

   task automatic wait_idle_a(input string tag);
      int n = 0;
      while (a_if.busy && n < 4000) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 64'(a_if.busy), 64'(0));
      tick();
      tick();
   endtask

   task automatic frame_done(input string tag, input int frames, input int lc0, input int bc0);
      wait_idle_a(tag);
      chk({tag, "_busy_len"}, 64'(last_busy), 64'(frames * FRAME_A));
      chk({tag, "_latches"},  64'(latch_cnt - lc0), 64'(frames));
      chk({tag, "_bytes"},    64'(byte_cnt - bc0), 64'(frames * DIGITS));
      chk({tag, "_drained"},  64'(exp_q.size()), 64'(0));
   endtask

   task automatic run_b_frame(input string tag, input logic [4*DIGITS-1:0] bcd,
                              input logic [DIGITS-1:0] dp);
      logic [7:0] bv;
      logic eb;
      int digit;
      b_if.digits_bcd = bcd;
      b_if.dp_mask    = dp;
      b_if.ref_pulse  = 1'b1;
      tick();
      b_if.ref_pulse  = 1'b0;
      for (int k = 0; k < NBITS; k++) begin
         digit = DIGITS - 1 - k / 8;
         bv = model_byte(bcd[4*digit +: 4], dp[digit], 1'b1);
         eb = bv[7 - (k % 8)];
         chk({tag, "_lo"}, 64'({b_if.busy, b_if.ser_latch, b_if.ser_clk, b_if.ser_data}),
             64'({1'b1, 1'b0, 1'b0, eb}));
         tick();
         chk({tag, "_hi"}, 64'({b_if.busy, b_if.ser_latch, b_if.ser_clk, b_if.ser_data}),
             64'({1'b1, 1'b0, 1'b1, eb}));
         tick();
      end
      chk({tag, "_latch"}, 64'({b_if.busy, b_if.ser_latch, b_if.ser_clk, b_if.ser_data}),
          64'(4'b1100));
      tick();
      chk({tag, "_idle"}, 64'({b_if.busy, b_if.ser_latch, b_if.ser_clk, b_if.ser_data}),
          64'(4'b0000));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [4*DIGITS-1:0] d1, d2;
      logic [DIGITS-1:0]   p1, p2;
      logic [7:0]          bv;
      int lc0, bc0;

      a_if.ref_pulse = 1'b0; a_if.digits_bcd = '0; a_if.dp_mask = '0;
      b_if.ref_pulse = 1'b0; b_if.digits_bcd = '0; b_if.dp_mask = '0;

      // Reset values
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_a_pins", 64'({a_if.busy, a_if.ser_latch, a_if.ser_clk, a_if.ser_data}), 64'(0));
      chk("rst_a_state", 64'(a_if.dbg_state), 64'(IDLE));
      chk("rst_b_pins", 64'({b_if.busy, b_if.ser_latch, b_if.ser_clk, b_if.ser_data}), 64'(0));
      reset = 1'b0;
      repeat (2) tick();

      // 1: plain digits
      set_a(24'h012345, 6'b000000);
      push_frame(24'h012345, 6'b000000);
      lc0 = latch_cnt; bc0 = byte_cnt;
      pulse_a();
      start_checks("t1", 1'b0);
      frame_done("t1", 1, lc0, bc0);

      // 2: blank digits keep their decimal point
      set_a(24'hFA9000, 6'b100000);
      push_frame(24'hFA9000, 6'b100000);
      lc0 = latch_cnt; bc0 = byte_cnt;
      pulse_a();
      start_checks("t2", 1'b1);
      frame_done("t2", 1, lc0, bc0);

      // 3: requests during a frame collapse into one, data taken at re-capture
      d1 = 24'($urandom); p1 = 6'($urandom);
      set_a(d1, p1);
      push_frame(d1, p1);
      lc0 = latch_cnt; bc0 = byte_cnt;
      pulse_a();
      set_a(24'h999999, 6'b000000);
      push_frame(24'h999999, 6'b000000);
      repeat (49) tick();
      a_if.ref_pulse = 1'b1;
      tick();
      tick();
      a_if.ref_pulse = 1'b0;
      frame_done("t3", 2, lc0, bc0);

      // 4: reset at cycle 100 of a frame with a request pending
      d1 = 24'($urandom); p1 = 6'($urandom);
      set_a(d1, p1);
      push_frame(d1, p1);
      pulse_a();
      repeat (49) tick();
      pulse_a();
      repeat (49) tick();
      chk("t4_busy_before_reset", 64'(a_if.busy), 64'(1));
      lc0 = latch_cnt;
      reset = 1'b1;
      #1;
      chk("t4_reset_pins", 64'({a_if.busy, a_if.ser_latch, a_if.ser_clk, a_if.ser_data}), 64'(0));
      chk("t4_reset_state", 64'(a_if.dbg_state), 64'(IDLE));
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      repeat (450) tick();
      chk("t4_stays_idle", 64'(a_if.busy), 64'(0));
      chk("t4_no_latch", 64'(latch_cnt - lc0), 64'(0));
      d1 = 24'($urandom); p1 = 6'($urandom);
      set_a(d1, p1);
      push_frame(d1, p1);
      lc0 = latch_cnt; bc0 = byte_cnt;
      pulse_a();
      bv = model_byte(d1[4*DIGITS-1 -: 4], p1[DIGITS-1], 1'b0);
      start_checks("t4_clean", bv[7]);
      frame_done("t4_clean", 1, lc0, bc0);

      // 6: request in the final latch cycle
      d1 = 24'($urandom); p1 = 6'($urandom);
      d2 = 24'($urandom); p2 = 6'($urandom);
      set_a(d1, p1);
      push_frame(d1, p1);
      lc0 = latch_cnt; bc0 = byte_cnt;
      pulse_a();
      repeat (FRAME_A - 1) tick();
      chk("t6_in_last_latch", 64'({a_if.busy, a_if.ser_latch}), 64'(2'b11));
      set_a(d2, p2);
      push_frame(d2, p2);
      pulse_a();
      bv = model_byte(d2[4*DIGITS-1 -: 4], p2[DIGITS-1], 1'b0);
      start_checks("t6_second", bv[7]);
      frame_done("t6", 2, lc0, bc0);

      // Random single frames
      for (int r = 0; r < 3; r++) begin
         d1 = 24'($urandom); p1 = 6'($urandom);
         set_a(d1, p1);
         push_frame(d1, p1);
         lc0 = latch_cnt; bc0 = byte_cnt;
         pulse_a();
         bv = model_byte(d1[4*DIGITS-1 -: 4], p1[DIGITS-1], 1'b0);
         start_checks("rnd", bv[7]);
         frame_done("rnd", 1, lc0, bc0);
      end

      // 5: common anode, CLK_DIV=1
      run_b_frame("t5_eights", 24'h888888, 6'b000000);
      tick();
      run_b_frame("t5_rnd", 24'($urandom), 6'($urandom));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
